// File: rtl/br_resolve.sv
// Branch resolution unit: carries fetch PC and prediction through ID/EX, flags mispredicts
// and issues a registered predictor update. Optional counters are built with BR_STATS_EN.
module br_resolve #(
    parameter int STATS_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Stall_i,
    input  logic               FetchValid_i,
    input  logic [31:0]        PcIF_i,
    input  logic               PredHit_i,
    input  logic [31:0]        PredTarget_i,
    input  logic               ExIsBranch_i,
    input  logic               ExTaken_i,
    input  logic [31:0]        ExTarget_i,
    output logic [31:0]        ExPc_o,
    output logic               Flush_o,
    output logic [31:0]        RedirectPc_o,
    output logic               WriteEn_o,
    output logic               BranchTaken_o,
    output logic [31:0]        WriteAddr_o,
    output logic [31:0]        WriteTarget_o,
    output logic [STATS_W-1:0] BrCount_o,
    output logic [STATS_W-1:0] MissCount_o
);

    logic        id_valid_q;
    logic [31:0] id_pc_q;
    logic        id_hit_q;
    logic [31:0] id_tgt_q;

    logic        ex_valid_q;
    logic [31:0] ex_pc_q;
    logic        ex_hit_q;
    logic [31:0] ex_tgt_q;
    logic        ex_resolved_q;

    logic        we_q;
    logic        taken_q;
    logic [31:0] waddr_q;
    logic [31:0] wtgt_q;

    logic        fire;
    logic        mispredict;
    logic        advance;

    assign advance    = ~Stall_i;
    assign fire       = ex_valid_q & ExIsBranch_i & ~ex_resolved_q;
    assign mispredict = fire & ((ExTaken_i != ex_hit_q) |
                                (ExTaken_i & (ExTarget_i != ex_tgt_q)));

    always_comb begin
        RedirectPc_o = 32'h0;
        if (mispredict) begin
            RedirectPc_o = ExTaken_i ? ExTarget_i : (ex_pc_q + 32'd4);
        end
    end

    assign Flush_o = mispredict;
    assign ExPc_o  = ex_pc_q;

    // ID record: a flush kills it even while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'h0;
            id_hit_q   <= 1'b0;
            id_tgt_q   <= 32'h0;
        end else if (advance) begin
            id_valid_q <= FetchValid_i & ~mispredict;
            id_pc_q    <= PcIF_i;
            id_hit_q   <= PredHit_i;
            id_tgt_q   <= PredTarget_i;
        end else if (mispredict) begin
            id_valid_q <= 1'b0;
        end
    end

    // EX record; resolved keeps a stalled branch from firing twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= 32'h0;
            ex_hit_q      <= 1'b0;
            ex_tgt_q      <= 32'h0;
            ex_resolved_q <= 1'b0;
        end else if (advance) begin
            ex_valid_q    <= id_valid_q & ~mispredict;
            ex_pc_q       <= id_pc_q;
            ex_hit_q      <= id_hit_q;
            ex_tgt_q      <= id_tgt_q;
            ex_resolved_q <= 1'b0;
        end else if (fire) begin
            ex_resolved_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            taken_q <= 1'b0;
            waddr_q <= 32'h0;
            wtgt_q  <= 32'h0;
        end else begin
            we_q <= fire;
            if (fire) begin
                taken_q <= ExTaken_i;
                waddr_q <= ex_pc_q;
                wtgt_q  <= ExTarget_i;
            end
        end
    end

    assign WriteEn_o     = we_q;
    assign BranchTaken_o = taken_q;
    assign WriteAddr_o   = waddr_q;
    assign WriteTarget_o = wtgt_q;

`ifdef BR_STATS_EN
    logic [STATS_W-1:0] br_cnt_q;
    logic [STATS_W-1:0] miss_cnt_q;

    // Saturating counters: stop at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (fire && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + 1'b1;
            end
            if (mispredict && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 1'b1;
            end
        end
    end

    assign BrCount_o   = br_cnt_q;
    assign MissCount_o = miss_cnt_q;
`else
    assign BrCount_o   = '0;
    assign MissCount_o = '0;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Directed bench for br_resolve: per-cycle comparison against a pipeline-of-instructions
// model plus literal expectations from the test plan.
module tb_br_resolve;

    localparam int STATS_W = 32;
`ifdef BR_STATS_EN
    localparam logic STATS_ON = 1'b1;
`else
    localparam logic STATS_ON = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               Stall_i;
    logic               FetchValid_i;
    logic [31:0]        PcIF_i;
    logic               PredHit_i;
    logic [31:0]        PredTarget_i;
    logic               ExIsBranch_i;
    logic               ExTaken_i;
    logic [31:0]        ExTarget_i;
    logic [31:0]        ExPc_o;
    logic               Flush_o;
    logic [31:0]        RedirectPc_o;
    logic               WriteEn_o;
    logic               BranchTaken_o;
    logic [31:0]        WriteAddr_o;
    logic [31:0]        WriteTarget_o;
    logic [STATS_W-1:0] BrCount_o;
    logic [STATS_W-1:0] MissCount_o;

    br_resolve #(.STATS_W(STATS_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .Stall_i       (Stall_i),
        .FetchValid_i  (FetchValid_i),
        .PcIF_i        (PcIF_i),
        .PredHit_i     (PredHit_i),
        .PredTarget_i  (PredTarget_i),
        .ExIsBranch_i  (ExIsBranch_i),
        .ExTaken_i     (ExTaken_i),
        .ExTarget_i    (ExTarget_i),
        .ExPc_o        (ExPc_o),
        .Flush_o       (Flush_o),
        .RedirectPc_o  (RedirectPc_o),
        .WriteEn_o     (WriteEn_o),
        .BranchTaken_o (BranchTaken_o),
        .WriteAddr_o   (WriteAddr_o),
        .WriteTarget_o (WriteTarget_o),
        .BrCount_o     (BrCount_o),
        .MissCount_o   (MissCount_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // pipe[0] is the younger instruction (decode), pipe[1] the older (execute).
    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        hit;
        logic [31:0] tgt;
    } rec_t;

    rec_t               pipe [2];
    logic               m_res;
    logic               m_we;
    logic               m_bt;
    logic [31:0]        m_wa;
    logic [31:0]        m_wt;
    logic [STATS_W-1:0] m_br;
    logic [STATS_W-1:0] m_miss;

    function automatic logic m_fire();
        return pipe[1].v && ExIsBranch_i && !m_res;
    endfunction

    function automatic logic m_wrong();
        logic bad_dir, bad_tgt;
        bad_dir = (ExTaken_i != pipe[1].hit);
        bad_tgt = ExTaken_i && (ExTarget_i != pipe[1].tgt);
        return m_fire() && (bad_dir || bad_tgt);
    endfunction

    function automatic logic [31:0] m_redirect();
        logic [31:0] seq;
        seq = pipe[1].pc + 32'd4;
        if (!m_wrong()) return 32'h0;
        return ExTaken_i ? ExTarget_i : seq;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                pipe[0] = '0; pipe[1] = '0; m_res = 1'b0;
                m_we = 1'b0; m_bt = 1'b0; m_wa = '0; m_wt = '0;
                m_br = '0; m_miss = '0;
            end else begin
                logic f, w;
                rec_t nf;
                f = m_fire();
                w = m_wrong();
                m_we = f;
                if (f) begin
                    m_bt = ExTaken_i; m_wa = pipe[1].pc; m_wt = ExTarget_i;
                end
                if (STATS_ON && f && m_br != '1) m_br = m_br + 1;
                if (STATS_ON && w && m_miss != '1) m_miss = m_miss + 1;
                // everything younger than a mispredicted branch is killed
                if (w) pipe[0].v = 1'b0;
                if (!Stall_i) begin
                    nf.v = FetchValid_i && !w; nf.pc = PcIF_i;
                    nf.hit = PredHit_i; nf.tgt = PredTarget_i;
                    pipe[1] = pipe[0];
                    pipe[0] = nf;
                    m_res = 1'b0;
                end else if (f) begin
                    m_res = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("flush",      {31'b0, Flush_o},       {31'b0, m_wrong()});
            check("redirect",   RedirectPc_o,           m_redirect());
            check("ex_pc",      ExPc_o,                 pipe[1].pc);
            check("write_en",   {31'b0, WriteEn_o},     {31'b0, m_we});
            check("br_taken",   {31'b0, BranchTaken_o}, {31'b0, m_bt});
            check("write_addr", WriteAddr_o,            m_wa);
            check("write_tgt",  WriteTarget_o,          m_wt);
            check("br_count",   BrCount_o,              m_br);
            check("miss_count", MissCount_o,            m_miss);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic fv, input logic [31:0] pc, input logic hit,
                        input logic [31:0] tgt, input logic st, input logic eb,
                        input logic et, input logic [31:0] etgt);
        @(posedge clk);
        #1;
        FetchValid_i = fv; PcIF_i = pc; PredHit_i = hit; PredTarget_i = tgt;
        Stall_i = st; ExIsBranch_i = eb; ExTaken_i = et; ExTarget_i = etgt;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic peek();
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    int          flush_cnt;
    int          we_cnt;
    logic [31:0] br_before;

    initial begin
        rst = 1'b0;
        FetchValid_i = 0; PcIF_i = 0; PredHit_i = 0; PredTarget_i = 0;
        Stall_i = 0; ExIsBranch_i = 0; ExTaken_i = 0; ExTarget_i = 0;
        #3;
        check("rst_flush", {31'b0, Flush_o}, 32'h0);
        check("rst_we",    {31'b0, WriteEn_o}, 32'h0);
        check("rst_expc",  ExPc_o, 32'h0);
        check("rst_wa",    WriteAddr_o, 32'h0);
        @(posedge clk); #1 rst = 1'b1;

        // predicted taken, correct
        step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h200);
        peek();
        check("t1_flush", {31'b0, Flush_o}, 32'h0);
        check("t1_expc",  ExPc_o, 32'h100);
        idle();
        peek();
        check("t1_we", {31'b0, WriteEn_o}, 32'h1);
        check("t1_wa", WriteAddr_o, 32'h100);
        check("t1_wt", WriteTarget_o, 32'h200);
        check("t1_bt", {31'b0, BranchTaken_o}, 32'h1);

        // predicted not taken, wrong; same-cycle fetch must be killed
        step(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();
        step(1'b1, 32'h44, 1'b1, 32'h900, 1'b0, 1'b1, 1'b1, 32'h80);
        peek();
        check("t2_flush",    {31'b0, Flush_o}, 32'h1);
        check("t2_redirect", RedirectPc_o, 32'h80);
        idle();
        peek();
        check("t2_we",   {31'b0, WriteEn_o}, 32'h1);
        check("t2_wa",   WriteAddr_o, 32'h40);
        check("t2_miss", MissCount_o, STATS_ON ? 32'd1 : 32'd0);
        check("t2_br",   BrCount_o,   STATS_ON ? 32'd2 : 32'd0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        peek();
        check("t2_killed_flush", {31'b0, Flush_o}, 32'h0);
        check("t2_killed_expc",  ExPc_o, 32'h44);
        idle();
        peek();
        check("t2_killed_we", {31'b0, WriteEn_o}, 32'h0);

        // wrong target
        step(1'b1, 32'h500, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h304);
        peek();
        check("t3_flush",    {31'b0, Flush_o}, 32'h1);
        check("t3_redirect", RedirectPc_o, 32'h304);
        idle();

        // predicted taken, not taken, PC wraps
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1234);
        peek();
        check("t4_flush",    {31'b0, Flush_o}, 32'h1);
        check("t4_redirect", RedirectPc_o, 32'h0);
        idle();
        peek();
        check("t4_wa",   WriteAddr_o, 32'hFFFF_FFFC);
        check("t4_wt",   WriteTarget_o, 32'h1234);
        check("t4_bt",   {31'b0, BranchTaken_o}, 32'h0);
        check("t4_br",   BrCount_o,   STATS_ON ? 32'd4 : 32'd0);
        check("t4_miss", MissCount_o, STATS_ON ? 32'd3 : 32'd0);

        // mispredicting branch held in EX by a 3-cycle stall
        step(1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();
        peek();
        br_before = BrCount_o;
        flush_cnt = 0;
        we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h640);
            else       idle();
            peek();
            if (i == 0) check("t5_first_flush", {31'b0, Flush_o}, 32'h1);
            flush_cnt += int'(Flush_o);
            we_cnt    += int'(WriteEn_o);
        end
        check("t5_flush_cycles", flush_cnt, 32'd1);
        check("t5_we_pulses",    we_cnt, 32'd1);
        check("t5_br_delta",     BrCount_o - br_before, STATS_ON ? 32'd1 : 32'd0);

        // reset asserted in the cycle the update would rise
        step(1'b1, 32'h700, 1'b1, 32'h800, 1'b0, 1'b0, 1'b0, 32'h0);
        idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h900);
        peek();
        check("t6_flush_pre", {31'b0, Flush_o}, 32'h1);
        #4 rst = 1'b0;
        #1;
        check("t6_flush",    {31'b0, Flush_o}, 32'h0);
        check("t6_redirect", RedirectPc_o, 32'h0);
        check("t6_expc",     ExPc_o, 32'h0);
        check("t6_wa",       WriteAddr_o, 32'h0);
        check("t6_wt",       WriteTarget_o, 32'h0);
        check("t6_br",       BrCount_o, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        FetchValid_i = 0; ExIsBranch_i = 0; ExTaken_i = 0; ExTarget_i = 0;
        peek();
        check("t6_we_after", {31'b0, WriteEn_o}, 32'h0);

        idle();
        idle();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
